// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry-lookahead slice swept LSB nibble first.
// Optional signed-overflow output enabled by defining SEQ_ADD_OVF_EN.

module four_bit_cla (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       g_out,
    output logic       p_out
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = x & y;
    assign p = x ^ y;

    // Lookahead carries into each bit position, all from cin in two gate levels
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign s     = p ^ c;
    assign g_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign p_out = &p;
endmodule

module cla_seq_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SEQ_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned K_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [K_W-1:0]   k;

    logic [3:0] slice_x;
    logic [3:0] slice_y;
    logic [3:0] slice_s;
    logic       slice_g;
    logic       slice_p;

    // Current nibble of each operand; {k,2'b00} is the bit offset 4k
    assign slice_x = op_a[{k, 2'b00} +: 4];
    assign slice_y = op_b[{k, 2'b00} +: 4];

    four_bit_cla u_cla (
        .x     (slice_x),
        .y     (slice_y),
        .cin   (carry),
        .s     (slice_s),
        .g_out (slice_g),
        .p_out (slice_p)
    );

    // The carry register holds the top-nibble group carry once DONE is reached
    assign cout = carry;

    // Control FSM with handshake flags registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            k         <= '0;
            sum       <= '0;
`ifdef SEQ_ADD_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a     <= a;
                        op_b     <= b;
                        carry    <= cin;
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum[{k, 2'b00} +: 4] <= slice_s;
                    carry                <= slice_g | (slice_p & carry);
                    if (k == K_LAST) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef SEQ_ADD_OVF_EN
                        ovf <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (slice_s[3] != op_a[WIDTH-1]);
`endif
                    end else begin
                        k <= k + K_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder (WIDTH=16): transaction-level model plus directed vectors.
`timescale 1ns/1ps

module tb_cla_seq_adder;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SEQ_ADD_OVF_EN
    logic             ovf;
`endif

    int total  = 0;
    int passed = 0;

    cla_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SEQ_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic ovf_ref(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        logic [WIDTH-1:0] s;
        s = x + y + WIDTH'(c);
        return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Transaction model: accept when idle, result after NIB cycles, held until taken
    typedef enum int {M_IDLE, M_BUSY, M_DONE} mphase_t;
    mphase_t        mph = M_IDLE;
    int             mcnt = 0;
    logic [WIDTH:0] exp_res = '0;
    logic           exp_ovf = 1'b0;
    int             cyc = 0;
    int             accepts = 0;
    int             results = 0;
    int             last_acc = 0;
    logic           b2b_mode = 1'b0;
    int             b2b_acc = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mph  <= M_IDLE;
            mcnt <= 0;
        end else begin
            cyc <= cyc + 1;
            case (mph)
                M_IDLE: if (in_valid) begin
                    exp_res  <= {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
                    exp_ovf  <= ovf_ref(a, b, cin);
                    mph      <= M_BUSY;
                    mcnt     <= 0;
                    accepts  <= accepts + 1;
                    last_acc <= cyc;
                    if (b2b_mode) begin
                        if (b2b_acc > 0) check("accept_spacing", 32'(cyc - last_acc), 32'(NIB + 2));
                        b2b_acc <= b2b_acc + 1;
                    end
                end
                M_BUSY: if (mcnt == NIB - 1) mph <= M_DONE; else mcnt <= mcnt + 1;
                M_DONE: if (out_ready) begin
                    mph     <= M_IDLE;
                    results <= results + 1;
                end
                default: mph <= M_IDLE;
            endcase
        end
    end

    // Every-cycle compare against the model, sampled on the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            check("in_ready", 32'(in_ready), 32'(mph == M_IDLE));
            check("out_valid", 32'(out_valid), 32'(mph == M_DONE));
            if (mph == M_DONE) begin
                check("sum", 32'(sum), 32'(exp_res[WIDTH-1:0]));
                check("cout", 32'(cout), 32'(exp_res[WIDTH]));
`ifdef SEQ_ADD_OVF_EN
                check("ovf", 32'(ovf), 32'(exp_ovf));
`endif
            end
        end
    end

    // Present one operation and return on the falling edge just after it is accepted
    task automatic send(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xc);
        int n;
        n = 0;
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) check("send_ready_timeout", 32'(0), 32'(1));
        a = xa; b = xb; cin = xc; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic directed(input string name, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                            input logic xc, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        int n;
        send(xa, xb, xc);
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, 32'(n), 32'(NIB + 1));
        check({name, "_sum"}, 32'(sum), 32'(es));
        check({name, "_cout"}, 32'(cout), 32'(ec));
        check({name, "_model_sum"}, 32'(exp_res), 32'({ec, es}));
`ifdef SEQ_ADD_OVF_EN
        check({name, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo !== exp_ovf) check({name, "_model_ovf"}, 32'(exp_ovf), 32'(eo));
`endif
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_after_take", 32'(in_ready), 32'(1));
    endtask

    initial begin
        int acc0;
        int res0;
        int n;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_sum", 32'(sum), 32'(0));
        check("rst_cout", 32'(cout), 32'(0));
        reset = 1'b0;
        @(negedge clk);

        directed("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        take_result();
        directed("7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        take_result();
        directed("neg_ovf", 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);
        take_result();

        // Result held while the consumer stalls; new requests are refused
        directed("hold", 16'h1234, 16'h0FCB, 1'b1, 16'h2200, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = i[0];
            @(negedge clk);
            check("hold_sum", 32'(sum), 32'(16'h2200));
            check("hold_cout", 32'(cout), 32'(0));
            check("hold_out_valid", 32'(out_valid), 32'(1));
            check("hold_in_ready", 32'(in_ready), 32'(0));
        end
        in_valid = 1'b0;
        acc0 = accepts;
        take_result();
        repeat (3) @(negedge clk);
        check("hold_no_extra_accept", 32'(accepts), 32'(acc0));

        // Reset in the middle of RUN discards the operation
        send(16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrun_in_ready", 32'(in_ready), 32'(1));
        check("midrun_out_valid", 32'(out_valid), 32'(0));
        check("midrun_sum", 32'(sum), 32'(0));
        check("midrun_cout", 32'(cout), 32'(0));
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrun_no_result", 32'(out_valid), 32'(0));
        end

        // Back-to-back random traffic with both handshakes tied high
        acc0 = accepts;
        res0 = results;
        b2b_mode = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            cin = 1'($urandom);
            n = 0;
            while (!in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) begin
                check("b2b_ready_timeout", 32'(0), 32'(1));
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n = 0;
        while (mph != M_IDLE && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_drain", 32'(mph == M_IDLE), 32'(1));
        check("b2b_accepts", 32'(accepts - acc0), 32'(200));
        check("b2b_results", 32'(results - res0), 32'(200));
        b2b_mode = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog");
    end
endmodule
